// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RV32IM field/immediate decode stage with a small output FIFO.
// Each accepted instruction word is decoded (format, sign-extended immediate,
// illegal flag) and written to the FIFO tail; the head entry drives the outputs.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous discard of all buffered entries
//   in_valid/in_ready/ins             input handshake and raw instruction
//   out_valid/out_ready               output handshake on the FIFO head
//   opcode, rd, funct3, rs1, rs2, funct7   raw slices of the head word
//   imm, fmt, illegal                 decoded head entry
// Optional feature: define IMM_GEN_ILLEGAL_CHECK_EN to flag unlisted opcodes
// as fmt=ILL/illegal=1; otherwise they decode as fmt=R with illegal tied 0.
module imm_gen_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [31:0]     word;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t          mem [BUF_DEPTH];
  entry_t          dec_c;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            accept;
  logic            pop;
  logic [31:0]     imm32_c;

  // Handshake flags come from the occupancy register only.
  assign in_ready  = (count != CW'(BUF_DEPTH));
  assign out_valid = (count != CW'(0));
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Combinational decode of the incoming word.
  always_comb begin
    dec_c         = '0;
    imm32_c       = 32'd0;
    dec_c.word    = ins;
    dec_c.fmt     = FMT_R;
    dec_c.illegal = 1'b0;
    case (ins[6:0])
      7'b0110011: dec_c.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: dec_c.fmt = FMT_I;
      7'b0100011: dec_c.fmt = FMT_S;
      7'b1100011: dec_c.fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_c.fmt = FMT_U;
      7'b1101111: dec_c.fmt = FMT_J;
      default: begin
`ifdef IMM_GEN_ILLEGAL_CHECK_EN
        dec_c.fmt     = FMT_ILL;
        dec_c.illegal = 1'b1;
`else
        dec_c.fmt     = FMT_R;
`endif
      end
    endcase
    case (dec_c.fmt)
      FMT_I:   imm32_c = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32_c = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32_c = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32_c = {ins[31:12], 12'b0};
      FMT_J:   imm32_c = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32_c = 32'd0;
    endcase
    // Signed size cast extends from bit 31 when XLEN is 64.
    dec_c.imm = XLEN'($signed(imm32_c));
  end

  // FIFO pointers and occupancy; flush wins over same-cycle accept/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (pop)    rd_ptr <= PW'(rd_ptr + 1'b1);
      case ({accept, pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so head outputs read 0 under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem[i] <= '0;
    end else if (accept && !flush) begin
      mem[wr_ptr] <= dec_c;
    end
  end

  // Head entry drives the outputs; fields are raw slices of the stored word.
  assign head    = mem[rd_ptr];
  assign opcode  = head.word[6:0];
  assign rd      = head.word[11:7];
  assign funct3  = head.word[14:12];
  assign rs1     = head.word[19:15];
  assign rs2     = head.word[24:20];
  assign funct7  = head.word[31:25];
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed-vector bench for imm_gen_stage. A 32-bit and a
// 64-bit instance share all inputs so immediates of both widths are checked.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] ins = 32'd0;

  logic        in_ready, out_valid, illegal;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;
  logic [31:0] imm;

  logic        in_ready64, out_valid64, illegal64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt64;
  logic [63:0] imm64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  imm_gen_stage #(.XLEN(64), .BUF_DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .ins(ins),
    .out_valid(out_valid64), .out_ready(out_ready),
    .opcode(opcode64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
    .funct7(funct7_64), .imm(imm64), .fmt(fmt64), .illegal(illegal64)
  );

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
  localparam logic [2:0] EXP_ILL_FMT = 3'd7;
  localparam logic       EXP_ILL     = 1'b1;
`else
  localparam logic [2:0] EXP_ILL_FMT = 3'd0;
  localparam logic       EXP_ILL     = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word for a single edge; no-op on handshake if in_ready is low.
  task automatic push(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    ins      = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] addi_word(input int unsigned n);
    addi_word = {12'(n), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  localparam int NV = 8;
  logic [31:0] vec_ins [NV];
  logic [2:0]  vec_fmt [NV];
  logic [31:0] vec_imm [NV];
  logic        vec_ill [NV];

  initial begin
    vec_ins[0] = 32'hFFF00093; vec_fmt[0] = 3'd1; vec_imm[0] = 32'hFFFFFFFF; vec_ill[0] = 1'b0;
    vec_ins[1] = 32'h0020A423; vec_fmt[1] = 3'd2; vec_imm[1] = 32'h00000008; vec_ill[1] = 1'b0;
    vec_ins[2] = 32'hFE000EE3; vec_fmt[2] = 3'd3; vec_imm[2] = 32'hFFFFFFFC; vec_ill[2] = 1'b0;
    vec_ins[3] = 32'h0080006F; vec_fmt[3] = 3'd5; vec_imm[3] = 32'h00000008; vec_ill[3] = 1'b0;
    vec_ins[4] = 32'h12345037; vec_fmt[4] = 3'd4; vec_imm[4] = 32'h12345000; vec_ill[4] = 1'b0;
    vec_ins[5] = 32'h80000037; vec_fmt[5] = 3'd4; vec_imm[5] = 32'h80000000; vec_ill[5] = 1'b0;
    vec_ins[6] = 32'h002081B3; vec_fmt[6] = 3'd0; vec_imm[6] = 32'h00000000; vec_ill[6] = 1'b0;
    vec_ins[7] = 32'h00000000; vec_fmt[7] = EXP_ILL_FMT; vec_imm[7] = 32'h0; vec_ill[7] = EXP_ILL;
  end

  initial begin
    int sent, got, cyc;
    logic acc, pp;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_fmt", 64'(fmt), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-word decode vectors, each popped before the next
    for (int i = 0; i < NV; i++) begin
      push(vec_ins[i]);
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_fmt", i), 64'(fmt), 64'(vec_fmt[i]));
      check($sformatf("v%0d_imm", i), 64'(imm), 64'(vec_imm[i]));
      check($sformatf("v%0d_ill", i), 64'(illegal), 64'(vec_ill[i]));
      check($sformatf("v%0d_imm64", i), imm64, {{32{vec_imm[i][31]}}, vec_imm[i]});
      if (i == 0) check("addi_rd", 64'(rd), 64'd1);
      if (i == 1) begin
        check("sw_rs1", 64'(rs1), 64'd1);
        check("sw_rs2", 64'(rs2), 64'd2);
        check("sw_funct3", 64'(funct3), 64'd2);
      end
      pop_one();
      check($sformatf("v%0d_drain", i), 64'(out_valid), 64'd0);
    end

    // Fields are raw slices regardless of format (lw x3,4(x1))
    push(32'h0040A183);
    check("lw_opcode", 64'(opcode), 64'h03);
    check("lw_rd", 64'(rd), 64'd3);
    check("lw_funct3", 64'(funct3), 64'd2);
    check("lw_rs1", 64'(rs1), 64'd1);
    check("lw_funct7", 64'(funct7), 64'd0);
    check("lw_imm", 64'(imm), 64'd4);
    pop_one();

    // Back-pressure then streaming: 10 addi words, imm encodes the index
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      in_valid  = (sent < 10);
      ins       = addi_word(sent);
      out_ready = (cyc >= 4) && (cyc % 3 != 0);
      if (cyc == 3) begin
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_head", 64'(imm), 64'd0);
      end
      acc = in_valid & in_ready;
      pp  = out_valid & out_ready;
      if (pp) begin
        check($sformatf("stream_imm%0d", got), 64'(imm), 64'(got));
        got++;
      end
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    if (got < 10) check("stream_timeout", 64'(got), 64'd10);
    check("stream_sent", 64'(sent), 64'd10);
    check("stream_empty", 64'(out_valid), 64'd0);

    // Flush with a same-cycle accept: all entries and the new word discarded
    push(32'h00100093);
    push(32'h00200093);
    @(negedge clk);
    in_valid = 1'b1; ins = 32'h00300093; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    push(32'h00400093);
    check("post_flush_imm", 64'(imm), 64'd4);
    pop_one();
    check("post_flush_empty", 64'(out_valid), 64'd0);

    // Reset mid-burst empties the buffer immediately
    push(32'h00500093);
    push(32'h00600093);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_imm", 64'(imm), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h00700093);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_imm", 64'(imm), 64'd7);
    pop_one();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
